// File: rtl/if_prefetch.sv
// Instruction prefetch unit: one outstanding req/ack fetch into a DEPTH-entry {pc,word} FIFO, flushed on redirect.
// Ack-to-inst_valid latency is 1 cycle; define PREFETCH_BYPASS_EN to forward an ack straight to IF when the FIFO is empty (latency 0).
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t         state_q;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    req_addr_q;
    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    word_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW:0]    count_q;

    logic           empty;
    logic           ack_ok;
    logic           byp_vld;
    logic           byp_take;
    logic           push;
    logic           pop;

    assign empty  = (count_q == '0);
    assign ack_ok = (state_q == WAIT) && mem_ack_i && !redirect_i;

`ifdef PREFETCH_BYPASS_EN
    // An ack into an empty FIFO is shown to IF in the same cycle; it is only stored if IF stalls.
    assign byp_vld  = ack_ok && empty;
    assign byp_take = byp_vld && !stall_i;
`else
    assign byp_vld  = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign push = ack_ok && !byp_take;
    assign pop  = !empty && !stall_i && !redirect_i;

    assign inst_valid_o = !empty || byp_vld;
    assign inst_o       = byp_vld ? mem_rdata_i : word_q[rd_ptr_q];
    assign inst_pc_o    = byp_vld ? req_addr_q  : pc_q[rd_ptr_q];
    assign mem_req_o    = (state_q != IDLE);
    assign mem_addr_o   = req_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
        end else if (redirect_i) begin
            fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            // The in-flight request must still see its ack; an ack arriving now retires it.
            case (state_q)
                WAIT:    state_q <= mem_ack_i ? IDLE : DISCARD;
                DISCARD: state_q <= mem_ack_i ? IDLE : DISCARD;
                default: state_q <= IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < CNT_FULL) begin
                        req_addr_q <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= WAIT;
                    end
                end
                WAIT:    if (mem_ack_i) state_q <= IDLE;
                DISCARD: if (mem_ack_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (push) begin
                pc_q[wr_ptr_q]   <= req_addr_q;
                word_q[wr_ptr_q] <= mem_rdata_i;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: behavioural memory with programmable ack delay, scoreboard of expected PCs.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        model_ack;
    logic        force_ack;

    int          checks    = 0;
    int          errors    = 0;
    int          delivered = 0;
    int          ack_delay = 1;
    bit          mem_en    = 1'b1;
    logic [31:0] exp_q    [$];
    logic [31:0] addr_log [$];

    always #5 clk = ~clk;

    assign mem_ack = model_ack | force_ack;

    if_prefetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic wait_deliv(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && delivered < target; i++) tick(1);
        chk(tag, 32'(delivered), 32'(target));
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
        checks++;
        assert (addr_log.size() > idx) else begin
            errors++;
            $error("FAIL %s observed=no_request expected=%h", tag, exp);
        end
        if (addr_log.size() > idx) chk(tag, addr_log[idx], exp);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc = pc;
        redirect    = 1'b1;
        exp_q.delete();
        tick(1);
        redirect    = 1'b0;
    endtask

    // Memory: acks ack_delay cycles after a request first appears, logs every request address.
    initial begin
        bit          busy;
        int          cnt;
        logic [31:0] cur;
        busy = 1'b0; cnt = 0; cur = '0;
        model_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            model_ack = 1'b0;
            if (rst || !mem_en || !mem_req) begin
                busy = 1'b0;
                cnt  = 0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    cur  = mem_addr;
                    addr_log.push_back(cur);
                end else begin
                    chk("mem_addr_stable", mem_addr, cur);
                end
                if (cnt >= ack_delay) begin
                    model_ack = 1'b1;
                    mem_rdata = word_of(cur);
                    busy      = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Consumer side: every instruction IF accepts must be the next expected PC.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && !stall && !redirect) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_inst observed=%h expected=none", inst_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("inst_pc_order", inst_pc, e);
                    chk("inst_word", inst, word_of(e));
                    delivered++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int s;
        int base;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b1; force_ack = 1'b0;
        tick(3);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Fill under stall: exactly four requests, then idle with a full FIFO.
        addr_log.delete();
        push_seq(32'h0, 16);
        rst = 1'b0;
        tick(30);
        chk("t1_num_req", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("t1_addr", i, 32'(i * 4));
        chk("t1_mem_req_idle", 32'(mem_req), 32'd0);
        chk("t1_inst_valid", 32'(inst_valid), 32'd1);
        chk("t1_head_pc", inst_pc, 32'h0);
        chk("t1_head_word", inst, word_of(32'h0));

        // Drain with immediate acks.
        ack_delay = 0;
        stall = 1'b0;
        wait_deliv("t2_delivered", 12, 200);

        // Redirect while waiting on 0x8; its late ack must be discarded.
        stall = 1'b1;
        ack_delay = 3;
        do_redirect(32'h0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (mem_req && mem_addr == 32'h8) found = 1'b1;
        end
        chk("t3_found_req8", 32'(found), 32'd1);
        s = addr_log.size();
        base = delivered;
        redirect_pc = 32'h40;
        redirect = 1'b1;
        exp_q.delete();
        push_seq(32'h40, 4);
        tick(1);
        redirect = 1'b0;
        stall = 1'b0;
        chk("t3_discard_req_held", 32'(mem_req), 32'd1);
        chk("t3_discard_addr_held", mem_addr, 32'h8);
        chk("t3_flushed", 32'(inst_valid), 32'd0);
        wait_deliv("t3_delivered", base + 4, 80);
        chk_log("t3_next_addr", s, 32'h40);

        // Redirect in the very cycle 0x8 is acked: no discard wait.
        stall = 1'b1;
        ack_delay = 1;
        do_redirect(32'h0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (mem_req && mem_ack && mem_addr == 32'h8) found = 1'b1;
        end
        chk("t4_found_ack8", 32'(found), 32'd1);
        s = addr_log.size();
        base = delivered;
        redirect_pc = 32'h80;
        redirect = 1'b1;
        exp_q.delete();
        push_seq(32'h80, 4);
        tick(1);
        redirect = 1'b0;
        stall = 1'b0;
        chk("t4_no_discard", 32'(mem_req), 32'd0);
        chk("t4_flushed", 32'(inst_valid), 32'd0);
        wait_deliv("t4_delivered", base + 4, 60);
        chk_log("t4_next_addr", s, 32'h80);

        // Unaligned redirect target and address wrap.
        ack_delay = 0;
        s = addr_log.size();
        base = delivered;
        do_redirect(32'h43);
        push_seq(32'h40, 2);
        wait_deliv("t5_unaligned_delivered", base + 2, 40);
        chk_log("t5_aligned_addr", s, 32'h40);
        s = addr_log.size();
        base = delivered;
        do_redirect(32'hFFFF_FFF8);
        push_seq(32'hFFFF_FFF8, 4);
        wait_deliv("t5_wrap_delivered", base + 4, 60);
        chk_log("t5_wrap_addr0", s, 32'hFFFF_FFF8);
        chk_log("t5_wrap_addr1", s + 1, 32'hFFFF_FFFC);
        chk_log("t5_wrap_addr2", s + 2, 32'h0);
        chk_log("t5_wrap_addr3", s + 3, 32'h4);

        // Redirect from idle-with-full-FIFO: first request two cycles later.
        stall = 1'b1;
        tick(20);
        chk("lat_full_idle", 32'(mem_req), 32'd0);
        do_redirect(32'h100);
        chk("lat_cycle1_req", 32'(mem_req), 32'd0);
        chk("lat_cycle1_valid", 32'(inst_valid), 32'd0);
        tick(1);
        chk("lat_cycle2_req", 32'(mem_req), 32'd1);
        chk("lat_cycle2_addr", mem_addr, 32'h100);

        // Reset mid-fetch, then a stale ack while idle is ignored.
        mem_en = 1'b0;
        tick(3);
        chk("rmf_pending_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("rmf_idle", 32'(mem_req), 32'd0);
        chk("rmf_addr_reset", mem_addr, 32'h0);
        chk("rmf_valid", 32'(inst_valid), 32'd0);
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        chk("stale_ack_no_push", 32'(inst_valid), 32'd0);
        chk("stale_ack_req", 32'(mem_req), 32'd1);
        chk("stale_ack_addr", mem_addr, 32'h0);
        base = delivered;
        push_seq(32'h0, 3);
        mem_en = 1'b1;
        stall = 1'b0;
        wait_deliv("rmf_delivered", base + 3, 40);

        // First ack into an empty FIFO.
        ack_delay = 1;
        base = delivered;
        do_redirect(32'h200);
        push_seq(32'h200, 2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req && mem_ack && mem_addr == 32'h200) found = 1'b1;
            else tick(1);
        end
        chk("byp_found_ack", 32'(found), 32'd1);
`ifdef PREFETCH_BYPASS_EN
        chk("byp_valid_in_ack", 32'(inst_valid), 32'd1);
        chk("byp_inst", inst, word_of(32'h200));
        chk("byp_inst_pc", inst_pc, 32'h200);
        tick(1);
        chk("byp_not_pushed", 32'(inst_valid), 32'd0);
`else
        chk("nobyp_valid_in_ack", 32'(inst_valid), 32'd0);
        tick(1);
        chk("nobyp_valid_next", 32'(inst_valid), 32'd1);
        chk("nobyp_inst_pc", inst_pc, 32'h200);
`endif
        wait_deliv("byp_delivered", base + 2, 40);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
